rmii_rx_frame_ctrl: RTL

//  Receive-frame buffer controller behind the RMII byte deserializer/FCS checker.
//  - Writes each received byte into an external single-port packet RAM used as a ring.
//  - On frame end, commits good frames as {start,len} descriptors and rewinds bad ones.
//  - CPU pops descriptors and releases their space. Single clock domain (eth_clk); CDC is external.

---
 rtl/rmii_rx_pkg.sv | 25 ++
 rtl/rx_desc_fifo.sv | 54 +++++
 rtl/rmii_rx_frame_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/rmii_rx_pkg.sv
// Shared types and defaults for the RMII receive frame buffer controller.
// The descriptor address field is sized for the default ring and should be widened if ADDR_W grows.
package rmii_rx_pkg;

    localparam int RX_ADDR_W    = 11;
    localparam int RX_LEN_W     = 11;
    localparam int RX_MAX_FRAME = 1518;
    localparam int RX_MIN_FRAME = 64;

    typedef enum logic [1:0] {
        RXC_IDLE,
        RXC_RECV,
        RXC_DROP
    } rxc_state_t;

    typedef struct packed {
        logic [RX_ADDR_W-1:0] addr;
        logic [RX_LEN_W-1:0]  len;
    } rx_desc_t;

    function automatic logic [15:0] satInc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/rx_desc_fifo.sv
// Synchronous descriptor FIFO with a show-ahead head entry and full/empty flags.
// DEPTH must be a power of two, at least 2.
module rx_desc_fifo
    import rmii_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     eth_clk,
    input  logic     rst,
    input  logic     push_i,
    input  rx_desc_t pushData_i,
    input  logic     pop_i,
    output rx_desc_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    rx_desc_t             mem_q [DEPTH];
    logic     [PTR_W:0]   wrPtr_q;
    logic     [PTR_W:0]   rdPtr_q;
    logic                 doPush;
    logic                 doPop;

    // The extra pointer bit distinguishes a full FIFO from an empty one.
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]) &&
                     (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign head_o  = mem_q[rdPtr_q[PTR_W-1:0]];

    always_ff @(posedge eth_clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + (PTR_W+1)'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge eth_clk) begin
        if (doPush) begin
            mem_q[wrPtr_q[PTR_W-1:0]] <= pushData_i;
        end
    end

endmodule

// File: rtl/rmii_rx_frame_ctrl.sv
// Receive-frame buffer controller: writes bytes into a packet RAM ring and commits good frames as descriptors.
// Optional frame statistics counters are built when RX_STATS_EN is defined.
module rmii_rx_frame_ctrl
    import rmii_rx_pkg::*;
#(
    parameter int ADDR_W     = RX_ADDR_W,
    parameter int DESC_DEPTH = 4,
    parameter int MAX_FRAME  = RX_MAX_FRAME,
    parameter int MIN_FRAME  = RX_MIN_FRAME
) (
    input  logic                eth_clk,
    input  logic                rst,
    input  logic                in_sof,
    input  logic [7:0]          in_byte,
    input  logic                in_valid,
    input  logic                in_eof,
    input  logic                in_fcs_ok,
    output logic                buf_we,
    output logic [ADDR_W-1:0]   buf_waddr,
    output logic [7:0]          buf_wdata,
    output logic                desc_valid,
    output logic [ADDR_W-1:0]   desc_addr,
    output logic [RX_LEN_W-1:0] desc_len,
    input  logic                desc_pop,
    output logic                drop_pulse,
    output logic [15:0]         rx_good_cnt,
    output logic [15:0]         rx_drop_cnt
);

    localparam int                  PTR_W      = ADDR_W + 1;
    localparam logic [PTR_W-1:0]    RING_BYTES = PTR_W'(1) << ADDR_W;
    localparam logic [PTR_W-1:0]    MAX_PTR    = PTR_W'(MAX_FRAME);
    localparam logic [RX_LEN_W-1:0] MAX_LEN    = RX_LEN_W'(MAX_FRAME);
    localparam logic [RX_LEN_W-1:0] MIN_LEN    = RX_LEN_W'(MIN_FRAME);

    rxc_state_t          state_q, state_d;
    logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]    start_q, start_d;
    logic [RX_LEN_W-1:0] len_q, len_d;
    logic                bufWe_q, bufWe_d;
    logic [ADDR_W-1:0]   bufWaddr_q, bufWaddr_d;
    logic [7:0]          bufWdata_q, bufWdata_d;
    logic                dropPulse_q, dropPulse_d;

    logic [PTR_W-1:0]    used;
    logic [PTR_W-1:0]    free;
    logic                admit;
    logic                push;
    logic                doPop;
    logic                fifoFull;
    logic                fifoEmpty;
    rx_desc_t            pushDesc;
    rx_desc_t            headDesc;

    // Admission uses the pointers as they stand this cycle, so a concurrent release never helps.
    assign used  = wrPtr_q - rdPtr_q;
    assign free  = RING_BYTES - used;
    assign admit = (free >= MAX_PTR) && !fifoFull;

    assign pushDesc.addr = RX_ADDR_W'(start_q[ADDR_W-1:0]);
    assign pushDesc.len  = len_q;

    assign doPop   = desc_pop && !fifoEmpty;
    assign rdPtr_d = doPop ? (rdPtr_q + PTR_W'(headDesc.len)) : rdPtr_q;

    rx_desc_fifo #(
        .DEPTH(DESC_DEPTH)
    ) u_desc_fifo (
        .eth_clk   (eth_clk),
        .rst       (rst),
        .push_i    (push),
        .pushData_i(pushDesc),
        .pop_i     (desc_pop),
        .head_o    (headDesc),
        .full_o    (fifoFull),
        .empty_o   (fifoEmpty)
    );

    always_ff @(posedge eth_clk) begin
        if (rst) begin
            state_q     <= RXC_IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            start_q     <= '0;
            len_q       <= '0;
            bufWe_q     <= 1'b0;
            bufWaddr_q  <= '0;
            bufWdata_q  <= '0;
            dropPulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            start_q     <= start_d;
            len_q       <= len_d;
            bufWe_q     <= bufWe_d;
            bufWaddr_q  <= bufWaddr_d;
            bufWdata_q  <= bufWdata_d;
            dropPulse_q <= dropPulse_d;
        end
    end

    // An aborting in_sof rewinds the partial frame and then runs the normal admission check.
    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        start_d     = start_q;
        len_d       = len_q;
        bufWe_d     = 1'b0;
        bufWaddr_d  = bufWaddr_q;
        bufWdata_d  = bufWdata_q;
        dropPulse_d = 1'b0;
        push        = 1'b0;
        unique case (state_q)
            RXC_IDLE, RXC_DROP: begin
                if (in_sof) begin
                    if (admit) begin
                        state_d = RXC_RECV;
                        start_d = wrPtr_q;
                        len_d   = '0;
                    end else begin
                        state_d     = RXC_DROP;
                        dropPulse_d = 1'b1;
                    end
                end else if (in_eof && (state_q == RXC_DROP)) begin
                    state_d = RXC_IDLE;
                end
            end
            RXC_RECV: begin
                if (in_sof) begin
                    wrPtr_d     = start_q;
                    dropPulse_d = 1'b1;
                    if (admit) begin
                        state_d = RXC_RECV;
                        start_d = start_q;
                        len_d   = '0;
                    end else begin
                        state_d = RXC_DROP;
                    end
                end else if (in_eof) begin
                    state_d = RXC_IDLE;
                    if (in_fcs_ok && (len_q >= MIN_LEN)) begin
                        push = 1'b1;
                    end else begin
                        wrPtr_d     = start_q;
                        dropPulse_d = 1'b1;
                    end
                end else if (in_valid) begin
                    if (len_q == MAX_LEN) begin
                        wrPtr_d     = start_q;
                        dropPulse_d = 1'b1;
                        state_d     = RXC_DROP;
                    end else begin
                        bufWe_d    = 1'b1;
                        bufWaddr_d = wrPtr_q[ADDR_W-1:0];
                        bufWdata_d = in_byte;
                        wrPtr_d    = wrPtr_q + PTR_W'(1);
                        len_d      = len_q + RX_LEN_W'(1);
                    end
                end
            end
            default: begin
                state_d = RXC_IDLE;
            end
        endcase
    end

    assign buf_we     = bufWe_q;
    assign buf_waddr  = bufWaddr_q;
    assign buf_wdata  = bufWdata_q;
    assign drop_pulse = dropPulse_q;
    assign desc_valid = !fifoEmpty;
    assign desc_addr  = fifoEmpty ? '0 : ADDR_W'(headDesc.addr);
    assign desc_len   = fifoEmpty ? '0 : headDesc.len;

`ifdef RX_STATS_EN
    logic [15:0] goodCnt_q;
    logic [15:0] dropCnt_q;

    // Both counters saturate rather than wrap so software can tell a flooded link apart.
    always_ff @(posedge eth_clk) begin
        if (rst) begin
            goodCnt_q <= '0;
            dropCnt_q <= '0;
        end else begin
            if (push) begin
                goodCnt_q <= satInc16(goodCnt_q);
            end
            if (dropPulse_d) begin
                dropCnt_q <= satInc16(dropCnt_q);
            end
        end
    end

    assign rx_good_cnt = goodCnt_q;
    assign rx_drop_cnt = dropCnt_q;
`else
    assign rx_good_cnt = '0;
    assign rx_drop_cnt = '0;
`endif

endmodule
